mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: BUSY cycles without mem_ack before abort; only used when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: rdata returned on an aborted transaction.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Ports: if_req in 1, if_addr in 32: instruction-fetch read request and word address.
REQ-007 Ports: if_gnt out 1, if_rvalid out 1, if_rdata out 32: fetch accepted pulse, completion pulse, read data.
REQ-008 Ports: d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_be in 4: data request, write enable, address, write data, byte enables.
REQ-009 Ports: d_gnt out 1, d_rvalid out 1, d_rdata out 32: data accepted pulse, completion pulse, load data.
REQ-010 Ports: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4: unified memory request.
REQ-011 Ports: mem_ack in 1, mem_rdata in 32: memory completion; mem_rdata valid with mem_ack.
REQ-012 Port: arb_err out 1: sticky timeout flag.

Function
REQ-013 FSM SHALL have states IDLE, BUSY_I, BUSY_D; exactly one transaction outstanding at a time.
REQ-014 In IDLE with a request pending, the clock edge SHALL register the winner's address, write enable, write data and byte enables onto mem_*, move to BUSY_I or BUSY_D, and pulse the matching gnt for exactly one cycle.
REQ-015 Requests SHALL only be sampled in IDLE; a requester holds req and payload until it sees gnt.
REQ-016 Single request: that requester wins; both pending: the winner is the requester not granted last (round-robin, last-grant register resets to "fetch", so data wins first).
REQ-017 mem_req SHALL stay high for the whole BUSY state; mem_* payload SHALL be stable while mem_req is high.
REQ-018 mem_ack in BUSY_x SHALL, at that edge, drop mem_req, return to IDLE, and set x_rvalid high for one cycle with x_rdata = mem_rdata.
REQ-019 For writes (d_we=1), d_rvalid SHALL still pulse on completion; d_rdata = 0.
REQ-020 For fetches, mem_we = 0 and mem_be = 4'hF regardless of stale data-port inputs.
REQ-021 mem_ack while in IDLE SHALL be ignored.
REQ-022 Minimum latency: req in cycle N, gnt and mem_req in N+1, mem_ack in N+1 gives rvalid in N+2; back-to-back grants are at most one per 2 cycles.
REQ-023 rdata outputs SHALL hold their last value between rvalid pulses.

Reset
REQ-024 Reset SHALL force IDLE, and clear mem_req, mem_we, gnt, rvalid and arb_err. mem_addr, mem_wdata, mem_be and rdata clear to 0. The last-grant register is set to fetch.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no rvalid; a mem_ack in the reset cycle is discarded.

Configuration
REQ-026 With MEM_ARB_TIMEOUT_EN defined:
- An 8-bit-minimum wait counter clears on entry to BUSY and increments each BUSY cycle.
- When the count reaches TIMEOUT_CYC without mem_ack, the abort SHALL drop mem_req, return to IDLE, pulse x_rvalid with x_rdata = ERR_DATA, and set arb_err until reset.
- mem_ack in the same cycle as the timeout wins, as a normal completion.
REQ-027 Without MEM_ARB_TIMEOUT_EN, the block waits indefinitely, arb_err is tied 0, and no counter is instantiated.

Structure
REQ-028 Package mips_mem_pkg SHALL hold the state enum (IDLE/BUSY_I/BUSY_D), the requester-id enum (REQ_IF/REQ_D) and the default TIMEOUT_CYC/ERR_DATA constants.
REQ-029 Sub-module arb_rr2 SHALL implement the 2-way round-robin pick: inputs req[1:0] and last, output winner id.

Verification
REQ-030 Fetch only: if_addr=0x00400000, mem_ack 3 cycles after mem_req with rdata=0x24080005. Required: if_gnt one cycle, mem_addr=0x00400000, if_rvalid one cycle after ack, if_rdata=0x24080005.
REQ-031 Simultaneous if_req and d_req (load, d_addr=0x10010000) out of reset. Required: data granted first, then fetch; no overlap of mem_req transactions.
REQ-032 Store d_we=1, d_be=4'b0011, d_wdata=0x0000ABCD. Required: mem_we=1, mem_be=0011, mem_wdata=0x0000ABCD; d_rvalid pulses with d_rdata=0.
REQ-033 Both requesters held high for 10 transactions with immediate ack. Required: strictly alternating grants D,I,D,I…, one grant per 2 cycles.
REQ-034 Reset asserted while in BUSY_D with mem_ack in the same cycle. Required: next cycle IDLE, mem_req=0, no d_rvalid.
REQ-035 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, never ack. Required: after 4 BUSY cycles, rvalid with rdata=0xDEADBEEF, arb_err=1 sticky until reset; without the macro, mem_req stays high indefinitely.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared types and defaults for the fetch/data memory port
//                arbiter. Holds the arbiter state encoding, the requester id,
//                the default abort timeout and the error read-data pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Bit positions of the request vector follow these values:
    // req[0] = fetch, req[1] = data.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam int          TIMEOUT_CYC_DEF = 255;
    localparam logic [31:0] ERR_DATA_DEF    = 32'hDEAD_BEEF;

    // Wait-counter width: wide enough for the timeout, never narrower than 8.
    function automatic int cnt_width(input int max_count);
        return ($clog2(max_count + 1) > 8) ? $clog2(max_count + 1) : 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr2
//  Description : Two-way round-robin pick. A lone requester wins; when both
//                request, the one that was not granted last wins.
//  Ports       : req[1:0] in  - request vector (bit0 fetch, bit1 data)
//                last     in  - id granted most recently
//                winner   out - id of the chosen requester
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = last;
        case (req)
            2'b01:   winner = REQ_IF;
            2'b10:   winner = REQ_D;
            2'b11:   winner = ~last;
            default: winner = last;   // no request: value is not consumed
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Arbitrates an instruction-fetch port and a data port onto a
//                single memory port with one transaction outstanding. Grants
//                are round-robin when both ports request. All outputs are
//                registered.
//  Ports       : clk, reset                     - clock, sync active-high reset
//                if_req/if_addr                 - fetch request
//                if_gnt/if_rvalid/if_rdata      - fetch accept, completion, data
//                d_req/d_we/d_addr/d_wdata/d_be - data request
//                d_gnt/d_rvalid/d_rdata         - data accept, completion, data
//                mem_req/mem_we/mem_addr/mem_wdata/mem_be - memory request
//                mem_ack/mem_rdata              - memory completion
//                arb_err                        - sticky timeout flag
//  Config      : MEM_ARB_TIMEOUT_EN - when defined, a transaction that sees no
//                mem_ack for TIMEOUT_CYC busy cycles is aborted and returns
//                ERR_DATA; otherwise the arbiter waits indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        arb_err
);

    arb_state_t  state_q,     state_d;
    req_id_t     last_q,      last_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic        if_gnt_q,    if_gnt_d;
    logic        d_gnt_q,     d_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q,  d_rvalid_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        arb_err_q,   arb_err_d;

    logic        w_winner;
    logic        w_timeout;

    arb_rr2 u_arb_rr2 (
        .req    ({d_req, if_req}),
        .last   (last_q),
        .winner (w_winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int             CNT_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Held at zero while idle, so it starts from zero on entry to BUSY and
    // then counts the busy cycles already spent waiting.
    always_comb begin
        wait_cnt_d = (state_q == IDLE) ? '0 : wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Fires in the last permitted busy cycle; mem_ack has priority below.
    assign w_timeout = (state_q != IDLE) && (wait_cnt_q == CNT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        arb_err_d   = arb_err_q;

        case (state_q)
            IDLE: begin
                // mem_ack is deliberately ignored here.
                if (if_req || d_req) begin
                    mem_req_d = 1'b1;
                    if (w_winner == REQ_D) begin
                        state_d     = BUSY_D;
                        last_d      = REQ_D;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                    end else begin
                        // Fetches are full-word reads whatever the data port
                        // happens to be presenting.
                        state_d     = BUSY_I;
                        last_d      = REQ_IF;
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'hF;
                    end
                end
            end

            BUSY_I: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata;
                end else if (w_timeout) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = ERR_DATA;
                    arb_err_d   = 1'b1;
                end
            end

            BUSY_D: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    d_rvalid_d = 1'b1;
                    // Stores still complete, but carry no load data.
                    d_rdata_d  = mem_we_q ? 32'h0 : mem_rdata;
                end else if (w_timeout) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = ERR_DATA;
                    arb_err_d  = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= REQ_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            arb_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            arb_err_q   <= arb_err_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign arb_err   = arb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A transaction-level
//                model predicts grants, completions, read data and the error
//                flag cycle by cycle from the requests and acks the bench
//                drives. Directed scenarios are followed by random traffic.
//  Config      : MEM_ARB_TIMEOUT_EN - enables the abort expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          TO      = 4;
    localparam logic [31:0] ERR_PAT = 32'hDEAD_BEEF;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        arb_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT_CYC (TO),
        .ERR_DATA    (ERR_PAT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .arb_err   (arb_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_busy;       // one transaction outstanding
    bit          m_owner_d;    // outstanding transaction belongs to data port
    bit          m_last_d;     // most recent grant went to data port
    int          m_age;        // busy cycles spent by outstanding transaction
    bit          m_err;
    logic [31:0] m_if_rdata, m_d_rdata;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_be;
    bit          m_wd_known;
    int          n_grants;

    // Stimulus knobs.
    int k_if_pct, k_d_pct, k_ack_pct, k_rst_pm;
    bit k_never_ack;

    // Advance one clock and compare every output with the model's prediction
    // from the inputs that were applied during the cycle just ended.
    task automatic step();
        bit e_ig, e_dg, e_iv, e_dv, pick_d, chk_pl, done, abort;
        logic [31:0] rd;
        e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; chk_pl = 0; done = 0; abort = 0;
        @(posedge clk);
        #1;
        if (reset) begin
            m_busy = 0; m_last_d = 0; m_err = 0;
            m_if_rdata = '0; m_d_rdata = '0;
            m_addr = '0; m_wdata = '0; m_we = 0; m_be = '0; m_wd_known = 1;
            chk_pl = 1;
        end else if (m_busy) begin
            m_age++;
            if (mem_ack) done = 1;
            else if (TO_EN && m_age == TO) abort = 1;
            if (done || abort) begin
                rd = abort ? ERR_PAT : (m_owner_d && m_we) ? 32'h0 : mem_rdata;
                if (m_owner_d) begin e_dv = 1; m_d_rdata = rd; end
                else begin e_iv = 1; m_if_rdata = rd; end
                if (abort) m_err = 1;
                m_busy = 0;
            end
        end else if (if_req || d_req) begin
            pick_d     = d_req && (!if_req || !m_last_d);
            m_busy     = 1;
            m_age      = 0;
            m_owner_d  = pick_d;
            m_last_d   = pick_d;
            n_grants++;
            if (pick_d) begin
                e_dg = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                m_be = d_be; m_wd_known = 1;
            end else begin
                e_ig = 1; m_addr = if_addr; m_we = 0; m_be = 4'hF; m_wd_known = 0;
            end
        end
        if (m_busy) chk_pl = 1;

        check_eq("if_gnt",    32'(if_gnt),    32'(e_ig));
        check_eq("d_gnt",     32'(d_gnt),     32'(e_dg));
        check_eq("if_rvalid", 32'(if_rvalid), 32'(e_iv));
        check_eq("d_rvalid",  32'(d_rvalid),  32'(e_dv));
        check_eq("mem_req",   32'(mem_req),   32'(m_busy));
        check_eq("arb_err",   32'(arb_err),   32'(m_err));
        check_eq("if_rdata",  if_rdata,       m_if_rdata);
        check_eq("d_rdata",   d_rdata,        m_d_rdata);
        if (chk_pl) begin
            check_eq("mem_addr", mem_addr,      m_addr);
            check_eq("mem_we",   32'(mem_we),   32'(m_we));
            check_eq("mem_be",   32'(mem_be),   32'(m_be));
            if (m_wd_known) check_eq("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    // Requesters hold req and payload until they see gnt; memory acks at
    // random (including while idle, which must be ignored).
    task automatic drive();
        reset = (k_rst_pm > 0) && ($urandom_range(999) < k_rst_pm);
        if (if_req && if_gnt) if_req = 0;
        else if (!if_req && $urandom_range(99) < k_if_pct) begin
            if_req  = 1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (d_req && d_gnt) d_req = 0;
        else if (!d_req && $urandom_range(99) < k_d_pct) begin
            d_req   = 1;
            d_we    = 1'($urandom);
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
            d_be    = 4'($urandom);
        end
        mem_ack   = k_never_ack ? 1'b0 : ($urandom_range(99) < k_ack_pct);
        mem_rdata = $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            drive();
        end
    endtask

    task automatic do_reset();
        reset = 1; if_req = 0; d_req = 0; mem_ack = 0;
        step();
        reset = 0;
    endtask

    initial begin
        reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_ack = 0; mem_rdata = '0;
        k_if_pct = 0; k_d_pct = 0; k_ack_pct = 0; k_rst_pm = 0; k_never_ack = 0;
        n_grants = 0;
        step();
        step();
        reset = 0;
        step();

        // Fetch only, ack three cycles after mem_req rises.
        if_req = 1; if_addr = 32'h0040_0000;
        step();
        if_req = 0;
        step();
        step();
        step();
        mem_ack = 1; mem_rdata = 32'h2408_0005;
        step();
        mem_ack = 0;
        check_eq("fetch_rdata", if_rdata, 32'h2408_0005);
        step();

        // Simultaneous fetch and load straight out of reset: data wins first.
        do_reset();
        if_req = 1; if_addr = 32'h0040_0004;
        d_req = 1; d_we = 0; d_addr = 32'h1001_0000; d_wdata = '0; d_be = 4'hF;
        k_ack_pct = 100;
        run(6);

        // Store: byte enables and write data reach memory, d_rdata reads 0.
        d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'h0000_ABCD; d_addr = 32'h1001_0010;
        mem_rdata = 32'h5555_5555;
        run(4);

        // Both ports held high with immediate ack: strict alternation.
        do_reset();
        k_if_pct = 100; k_d_pct = 100; k_ack_pct = 100;
        n_grants = 0;
        run(20);
        check_eq("alt_grants", 32'(n_grants), 32'd10);

        // Reset while BUSY_D with a simultaneous mem_ack.
        k_if_pct = 0; k_d_pct = 0; k_ack_pct = 0;
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h1001_0020;
        step();
        d_req = 0;
        reset = 1; mem_ack = 1; mem_rdata = 32'h1234_5678;
        step();
        reset = 0; mem_ack = 0;
        step();

        // Memory never acks.
        if_req = 1; if_addr = 32'h0040_0100;
        k_if_pct = 100; k_never_ack = 1;
        run(40);
        k_never_ack = 0; k_if_pct = 0;
        do_reset();
        step();

        // Random traffic with occasional reset.
        k_if_pct = 40; k_d_pct = 40; k_ack_pct = 35; k_rst_pm = 3;
        run(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
